// File: rtl/pwm_cfg_sequencer.sv
// AXI4-Lite master that programs four PWM registers from a snapshot taken at start.
// Optionally verifies each write by readback; every handshake wait is bounded.
module pwm_cfg_sequencer #(
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_TIMEOUT          = 255,
  parameter bit C_VERIFY           = 1'b1
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          start,
  input  logic [127:0]                  cfg_data,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [1:0]                    err_code,
  output logic [1:0]                    err_idx,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [31:0]                   M_AXI_WDATA,
  output logic [3:0]                    M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [31:0]                   M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam int TW = $clog2(C_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WRESP, S_RADDR, S_RDATA, S_FIN} state_t;

  state_t           r_state, w_next;
  logic [1:0]       r_idx;
  logic [3:0][31:0] r_shadow;
  logic             r_aw_done, r_w_done;
  logic [TW-1:0]    r_tmo;
  logic [1:0]       r_err_code, r_err_idx;

  logic       w_aw_hs, w_w_hs, w_hs, w_inc, w_tmo;
  logic [1:0] w_fail;

  assign w_aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_w_hs  = M_AXI_WVALID && M_AXI_WREADY;
  assign w_tmo   = (r_tmo == TW'(C_TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    w_fail = 2'b00;
    w_hs   = 1'b0;
    w_inc  = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_WR;
      S_WR: begin
        w_hs = w_aw_hs | w_w_hs;
        if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) w_next = S_WRESP;
        else if (!w_hs && w_tmo) begin w_next = S_FIN; w_fail = 2'b11; end
      end
      S_WRESP: begin
        if (M_AXI_BVALID) begin
          w_hs = 1'b1;
          if (M_AXI_BRESP != 2'b00) begin w_next = S_FIN; w_fail = 2'b01; end
          else if (C_VERIFY) w_next = S_RADDR;
          else w_inc = 1'b1;
        end else if (w_tmo) begin w_next = S_FIN; w_fail = 2'b11; end
      end
      S_RADDR: begin
        if (M_AXI_ARREADY) begin w_hs = 1'b1; w_next = S_RDATA; end
        else if (w_tmo) begin w_next = S_FIN; w_fail = 2'b11; end
      end
      S_RDATA: begin
        if (M_AXI_RVALID) begin
          w_hs = 1'b1;
          if (M_AXI_RRESP != 2'b00 || M_AXI_RDATA != r_shadow[r_idx]) begin
            w_next = S_FIN; w_fail = 2'b10;
          end else w_inc = 1'b1;
        end else if (w_tmo) begin w_next = S_FIN; w_fail = 2'b11; end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_inc) w_next = (r_idx == 2'd3) ? S_FIN : S_WR;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state    <= S_IDLE;
      r_idx      <= 2'd0;
      r_shadow   <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_tmo      <= '0;
      r_err_code <= 2'b00;
      r_err_idx  <= 2'b00;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_shadow   <= cfg_data;
        r_idx      <= 2'd0;
        r_err_code <= 2'b00;
        r_err_idx  <= 2'b00;
      end
      if (w_inc && r_idx != 2'd3) r_idx <= r_idx + 2'd1;
      if (w_fail != 2'b00) begin
        r_err_code <= w_fail;
        r_err_idx  <= r_idx;
      end
      // the wait budget restarts on every phase change and on every handshake
      if (w_next != r_state || w_hs) r_tmo <= '0;
      else if (r_state != S_IDLE && r_state != S_FIN) r_tmo <= r_tmo + TW'(1);
      // AW and W complete independently; the flags live only within one WR visit
      r_aw_done <= (r_state == S_WR && w_next == S_WR) ? (r_aw_done | w_aw_hs) : 1'b0;
      r_w_done  <= (r_state == S_WR && w_next == S_WR) ? (r_w_done  | w_w_hs)  : 1'b0;
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_FIN);
  assign err      = |r_err_code;
  assign err_code = r_err_code;
  assign err_idx  = r_err_idx;

  assign M_AXI_AWADDR  = C_S_AXI_ADDR_WIDTH'({r_idx, 2'b00});
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = (r_state == S_WR) && !r_aw_done;
  assign M_AXI_WDATA   = r_shadow[r_idx];
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = (r_state == S_WR) && !r_w_done;
  assign M_AXI_BREADY  = (r_state == S_WRESP);
  assign M_AXI_ARADDR  = C_S_AXI_ADDR_WIDTH'({r_idx, 2'b00});
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = (r_state == S_RADDR);
  assign M_AXI_RREADY  = (r_state == S_RDATA);

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Bench for pwm_cfg_sequencer: reactive AXI4-Lite slave plus scoreboards for
// register writes and sequence results, fed by directed sequences.
module tb_pwm_cfg_sequencer;
  localparam int TMO = 255;

  logic         ACLK = 1'b0, ARESET = 1'b1, start = 1'b0;
  logic [127:0] cfg_data = '0;
  logic         busy, done, err;
  logic [1:0]   err_code, err_idx;
  logic [3:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
  logic [1:0]   bresp = 0, rresp = 0;
  logic [31:0]  rdata = 0;

  pwm_cfg_sequencer #(.C_S_AXI_ADDR_WIDTH(4), .C_TIMEOUT(TMO), .C_VERIFY(1'b1)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .cfg_data(cfg_data),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .err_idx(err_idx),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  always #5 ACLK = ~ACLK;

  int n_tests = 0, n_fail = 0;
  logic [35:0] wr_q[$];
  logic [4:0]  done_q[$];

  // slave behaviour knobs (-1 = disabled)
  int aw_dly = 0, w_dly = 0, bresp_err_reg = -1, corrupt_reg = -1, ar_never_reg = -1;
  int aw_cnt = 0, ar_cnt = 0, done_cnt = 0, arv_cycles = 0;

  logic [31:0] mem [0:3];
  logic        pv_aw = 0, pv_w = 0, pv_b = 0, pv_ar = 0, pv_r = 0, prev_done = 0;
  logic        aw_got = 0, w_got = 0, ar_got = 0;
  logic [3:0]  p_awaddr = 0, p_araddr = 0, aw_a = 0, ar_a = 0, p_wstrb = 0, w_s = 0;
  logic [2:0]  p_awprot = 0, aw_p = 0;
  logic [31:0] p_wdata = 0, w_d = 0;
  logic [35:0] exp_wr;
  int          aw_wait = 0, w_wait = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave + monitors. Values sampled on a falling edge are the ones the DUT saw
  // at the following rising edge, so handshakes are reconstructed one edge later.
  always @(negedge ACLK) begin
    if (ARESET) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      bresp = 0; rresp = 0; rdata = 0;
      aw_got = 0; w_got = 0; ar_got = 0; aw_wait = 0; w_wait = 0;
      pv_aw = 0; pv_w = 0; pv_b = 0; pv_ar = 0; pv_r = 0; prev_done = 0;
    end else begin
      if (pv_aw && !awready && !done) check("awvalid_hold", awvalid, 1);
      if (pv_w && !wready && !done)   check("wvalid_hold", wvalid, 1);
      if (pv_ar && !arready && !done) check("arvalid_hold", arvalid, 1);
      if (pv_aw && awready) begin aw_got = 1; aw_a = p_awaddr; aw_p = p_awprot; aw_cnt++; aw_wait = 0; end
      if (pv_w && wready)   begin w_got = 1; w_d = p_wdata; w_s = p_wstrb; w_wait = 0; end
      if (pv_b && bvalid)   bvalid = 0;
      if (pv_ar && arready) begin ar_got = 1; ar_a = p_araddr; ar_cnt++; end
      if (pv_r && rvalid)   rvalid = 0;
      if (aw_got && w_got) begin
        if (wr_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_write: addr %0h data %0h, none expected", aw_a, w_d);
        end else begin
          exp_wr = wr_q.pop_front();
          check("write_addr_data", {aw_a, w_d}, exp_wr);
          check("wstrb_awprot", {w_s, aw_p}, {4'hF, 3'b000});
        end
        mem[aw_a[3:2]] = w_d;
        bvalid = 1;
        bresp  = (int'(aw_a[3:2]) == bresp_err_reg) ? 2'b10 : 2'b00;
        aw_got = 0; w_got = 0;
      end
      if (ar_got) begin
        rvalid = 1; rresp = 2'b00;
        rdata  = (int'(ar_a[3:2]) == corrupt_reg) ? 32'hDEAD : mem[ar_a[3:2]];
        ar_got = 0;
      end
      if (awvalid) begin awready = (aw_wait >= aw_dly); aw_wait++; end else awready = 0;
      if (wvalid)  begin wready  = (w_wait >= w_dly);   w_wait++;  end else wready  = 0;
      arready = arvalid && (int'(araddr[3:2]) != ar_never_reg);
      if (arvalid) arv_cycles++;
      // sequence-result scoreboard
      if (prev_done) check("done_one_cycle", {done, busy}, 2'b00);
      if (done) begin
        done_cnt++;
        if (done_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_done: err/code/idx %0h, none expected", {err, err_code, err_idx});
        end else check("result_err_code_idx", {err, err_code, err_idx}, done_q.pop_front());
      end
      prev_done = done;
      pv_aw = awvalid; p_awaddr = awaddr; p_awprot = awprot;
      pv_w = wvalid; p_wdata = wdata; p_wstrb = wstrb;
      pv_b = bready; pv_ar = arvalid; p_araddr = araddr; pv_r = rready;
    end
  end

  // res = {err, err_code, err_idx}; nwr writes and nrd reads are expected
  task automatic run_seq(input logic [127:0] cfg, input int nwr, input int nrd,
                         input logic [4:0] res, input bit poke);
    int a0, r0, k;
    for (int i = 0; i < nwr; i++) wr_q.push_back({4'(i * 4), cfg[32*i +: 32]});
    done_q.push_back(res);
    a0 = aw_cnt; r0 = ar_cnt;
    @(negedge ACLK); cfg_data = cfg; start = 1;
    @(negedge ACLK); start = 0;
    check("busy_after_start", busy, 1);
    if (poke) begin
      repeat (2) @(negedge ACLK);
      cfg_data = ~cfg; start = 1;
      @(negedge ACLK); start = 0;
    end
    k = 0;
    while (!done && k < 2000) begin @(negedge ACLK); k++; end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles, done required", k);
    end
    if (poke) start = 1;
    @(negedge ACLK); start = 0;
    if (poke) check("fin_start_ignored", busy, 0);
    @(negedge ACLK);
    check("writes_outstanding", wr_q.size(), 0);
    check("results_outstanding", done_q.size(), 0);
    check("aw_handshakes", aw_cnt - a0, nwr);
    check("ar_handshakes", ar_cnt - r0, nrd);
    check("err_held", {err, err_code, err_idx}, res);
  endtask

  initial begin
    int v0, k;
    @(negedge ACLK);
    check("reset_state", {busy, done, err, err_code, err_idx, awvalid, wvalid, bready, arvalid, rready}, 0);
    @(negedge ACLK); ARESET = 0;
    repeat (2) @(negedge ACLK);

    // zero-wait slave, with a start pulse while busy and one in the FIN cycle
    run_seq({32'h4, 32'h3, 32'h2, 32'h1}, 4, 4, 5'b00000, 1'b1);
    // AWREADY trails WREADY by 3 cycles, then the reverse
    aw_dly = 3; w_dly = 0;
    run_seq({32'hCAFE0003, 32'h12345678, 32'h0000FFFF, 32'h80000001}, 4, 4, 5'b00000, 1'b0);
    aw_dly = 0; w_dly = 3;
    run_seq({32'h00000000, 32'hFFFFFFFF, 32'h5A5A5A5A, 32'hA5A5A5A5}, 4, 4, 5'b00000, 1'b0);
    w_dly = 0;
    // BRESP error on register 2
    bresp_err_reg = 2;
    run_seq({32'h40, 32'h30, 32'h20, 32'h10}, 3, 2, 5'b10110, 1'b0);
    bresp_err_reg = -1;
    // readback of register 1 corrupted
    corrupt_reg = 1;
    run_seq({32'h0400, 32'h0300, 32'h1111, 32'h0100}, 2, 2, 5'b11001, 1'b0);
    corrupt_reg = -1;
    // ARREADY never comes for register 0
    ar_never_reg = 0; v0 = arv_cycles;
    run_seq({32'h7, 32'h6, 32'h5, 32'h9}, 1, 0, 5'b11100, 1'b0);
    check("ar_timeout_cycles", arv_cycles - v0, TMO);
    check("arvalid_after_timeout", arvalid, 0);
    ar_never_reg = -1;

    // reset in the middle of the register-1 write (AW stalled)
    aw_dly = 3;
    wr_q.push_back({4'h0, 32'h11});
    @(negedge ACLK); cfg_data = {32'h44, 32'h33, 32'h22, 32'h11}; start = 1;
    @(negedge ACLK); start = 0;
    k = 0;
    while (!(awvalid && awaddr == 4'h4) && k < 200) begin @(negedge ACLK); k++; end
    check("reached_wr_reg1", {awvalid, awaddr}, {1'b1, 4'h4});
    #2 ARESET = 1;
    #1 check("async_reset_outputs",
             {busy, done, err, err_code, err_idx, awvalid, wvalid, bready, arvalid, rready}, 0);
    repeat (2) @(negedge ACLK);
    ARESET = 0;
    check("reset_writes_outstanding", wr_q.size(), 0);
    aw_dly = 0;
    repeat (2) @(negedge ACLK);
    run_seq({32'h4, 32'h3, 32'h2, 32'h1}, 4, 4, 5'b00000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, finish required", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pwm_cfg_sequencer.md
PWM_CFG_SEQUENCER -- requirements
Module: pwm_cfg_sequencer

Interface
REQ-001 Parameter C_S_AXI_ADDR_WIDTH, default 4: AXI4-Lite address width; four 32-bit PWM registers at 0x0/0x4/0x8/0xC.
REQ-002 Parameter C_TIMEOUT, default 255: maximum cycles any single AXI phase may wait for its handshake.
REQ-003 Parameter C_VERIFY, default 1: when 1, each written register is read back and compared.
REQ-004 ACLK  in  1  the single clock; all logic is on its rising edge.
REQ-005 ARESET  in  1  reset, asynchronous and active-high.
REQ-006 start  in  1  one-cycle pulse; begins a programming sequence; ignored while busy.
REQ-007 cfg_data  in  128  four register values; reg n = cfg_data[32n+31:32n]; sampled into a shadow on the accepted start.
REQ-008 busy / done / err  out  1 each  sequence active / one-cycle completion pulse / sticky error flag.
REQ-009 err_code  out  2  00 none, 01 BRESP not OKAY, 10 RRESP not OKAY or readback mismatch, 11 timeout.
REQ-010 err_idx  out  2  register index at which the error occurred.
REQ-011 M_AXI write channels: AWADDR(addr width) AWPROT(3) AWVALID out, AWREADY in; WDATA(32) WSTRB(4) WVALID out, WREADY in; BRESP(2) BVALID in, BREADY out.
REQ-012 M_AXI read channels: ARADDR(addr width) ARPROT(3) ARVALID out, ARREADY in; RDATA(32) RRESP(2) RVALID in, RREADY out.

Function
REQ-013 FSM states: IDLE, WR (AW+W), WRESP, RADDR, RDATA, FIN; 2-bit index idx.
REQ-014 IDLE: on start, capture cfg_data to shadow, clear err/err_code/err_idx, idx=0, enter WR next cycle; busy=1 from that cycle until return to IDLE.
REQ-015 WR: AWVALID and WVALID both asserted in the first WR cycle; AWADDR={idx,2'b00}, WDATA=shadow[idx], WSTRB=4'hF, AWPROT=ARPROT=3'b000.
REQ-016 AWVALID drops the cycle after AWREADY=1 is sampled; WVALID likewise on WREADY, independently; either order or simultaneous handshake accepted; VALID never drops before its handshake.
REQ-017 When both handshakes have occurred, enter WRESP with BREADY=1; on BVALID: BRESP=00 -> RADDR if C_VERIFY=1 else next-index step; BRESP!=00 -> FIN with err_code=01.
REQ-018 RADDR: ARVALID=1, ARADDR={idx,2'b00} until ARREADY; then RDATA with RREADY=1.
REQ-019 RDATA: on RVALID, RRESP!=00 or RDATA!=shadow[idx] -> FIN with err_code=10; else next-index step.
REQ-020 Next-index step: idx=3 -> FIN; otherwise idx+1 and return to WR.
REQ-021 Timeout counter clears on every state entry and each completed handshake; on reaching C_TIMEOUT while in WR/WRESP/RADDR/RDATA -> FIN with err_code=11; outstanding VALIDs deassert on entry to FIN.
REQ-022 FIN lasts exactly one cycle: done=1, busy=0 next cycle, return to IDLE; err=1 iff err_code!=00, held until next accepted start.
REQ-023 err_idx = idx at the moment of failure; only one transaction outstanding at any time.
REQ-024 start asserted while busy has no effect; start in the FIN cycle is ignored.

Reset
REQ-025 ARESET=1 asynchronously forces IDLE, idx=0, all VALID/READY outputs 0, busy=done=err=0, err_code=err_idx=0, shadow=0, counters=0; reset mid-transaction abandons it without completing any handshake.

Verification
REQ-026 Zero-wait slave, cfg_data={32'h4,32'h3,32'h2,32'h1}, start -> writes 1,2,3,4 to 0x0..0xC, readbacks match, done pulse, err=0.
REQ-027 Slave AWREADY 3 cycles after WREADY, then reversed order -> each VALID held until own handshake, single write per register, done, err=0.
REQ-028 Slave returns BRESP=2'b10 on register 2 -> no further transactions, done, err=1, err_code=01, err_idx=2.
REQ-029 Slave corrupts RDATA of register 1 (returns 0xDEAD) -> done, err_code=10, err_idx=1, no write to 0x8.
REQ-030 Slave never asserts ARREADY on register 0 -> FIN after C_TIMEOUT cycles, err_code=11, err_idx=0, ARVALID=0 afterward.
REQ-031 ARESET pulsed mid-WR on register 1 -> all outputs at reset values immediately; subsequent start runs full clean sequence.
